// File: rtl/riscv_ckpt_checker.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ckpt_checker
// Purpose  : Checkpoint checker that runs beside a RISC-V core. A table of
//            {instruction count, expected output, compare mask} entries is
//            loaded over a config port. During a run the block watches the
//            core's NUM_INST / OUTPUT_PORT / HALT. It reports pass or fail,
//            together with the index and cause of the first failure.
// Ports    : CLK, RSTn            - clock, asynchronous active-low reset
//            CFG_WE/ADDR/NUM_INST/ANS/MASK - table write port (IDLE/DONE only)
//            CFG_COUNT, START     - number of valid entries, run start
//            NUM_INST, OUTPUT_PORT, HALT - observed core signals
//            BUSY, DONE, PASS     - run status
//            FAIL_IDX, FAIL_CODE  - first failure (1 mismatch, 2 missed,
//                                   3 incomplete/timeout)
//            FAIL_CNT, CYCLE      - saturating failure / run-cycle counters
//            CUR_IDX              - next entry to be checked
// Revision : 1.0 - initial release
// ============================================================================
module riscv_ckpt_checker #(
  parameter int NUM_CKPT     = 64,
  parameter int IDXW         = 6,
  parameter int IW           = 32,
  parameter int DW           = 32,
  parameter int CW           = 32,
  parameter int TIMEOUT      = 10000000,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            CFG_WE,
  input  logic [IDXW-1:0] CFG_ADDR,
  input  logic [IW-1:0]   CFG_NUM_INST,
  input  logic [DW-1:0]   CFG_ANS,
  input  logic [DW-1:0]   CFG_MASK,
  input  logic [IDXW:0]   CFG_COUNT,
  input  logic            START,
  input  logic [IW-1:0]   NUM_INST,
  input  logic [DW-1:0]   OUTPUT_PORT,
  input  logic            HALT,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [IDXW-1:0] FAIL_IDX,
  output logic [1:0]      FAIL_CODE,
  output logic [IDXW:0]   FAIL_CNT,
  output logic [CW-1:0]   CYCLE,
  output logic [IDXW:0]   CUR_IDX
);

  localparam logic [1:0]    S_IDLE     = 2'd0;
  localparam logic [1:0]    S_RUN      = 2'd1;
  localparam logic [1:0]    S_DONE     = 2'd2;
  localparam logic [IDXW:0] NUM_CKPT_W = (IDXW+1)'(NUM_CKPT);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
  localparam bit            TO_EN      = (TIMEOUT != 0);
  localparam bit            STOP_EN    = (STOP_ON_FAIL != 0);

  // Checkpoint table (deliberately not reset so it survives a warm reset)
  logic [IW-1:0] ni_mem   [NUM_CKPT];
  logic [DW-1:0] ans_mem  [NUM_CKPT];
  logic [DW-1:0] mask_mem [NUM_CKPT];

  logic [1:0]      state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [IDXW-1:0] fail_idx_q, fail_idx_d;
  logic [1:0]      fail_code_q, fail_code_d;
  logic [IDXW:0]   fail_cnt_q, fail_cnt_d;
  logic [CW-1:0]   cycle_q, cycle_d;
  logic [IDXW:0]   ptr_q, ptr_d;
  logic [IDXW:0]   count_q, count_d;

  logic            w_cfg_ok;
  logic [IDXW-1:0] w_rd_idx;
  logic [IW-1:0]   w_e_ni;
  logic [DW-1:0]   w_e_ans;
  logic [DW-1:0]   w_e_mask;
  logic            w_fail;
  logic [1:0]      w_code;
  logic            w_tmo;
  logic            w_end;

  assign w_cfg_ok = CFG_WE && (state_q != S_RUN) && ({1'b0, CFG_ADDR} < NUM_CKPT_W);

  always_ff @(posedge CLK) begin
    if (w_cfg_ok) begin
      ni_mem[CFG_ADDR]   <= CFG_NUM_INST;
      ans_mem[CFG_ADDR]  <= CFG_ANS;
      mask_mem[CFG_ADDR] <= CFG_MASK;
    end
  end

  assign w_rd_idx = ptr_q[IDXW-1:0];
  assign w_e_ni   = ni_mem[w_rd_idx];
  assign w_e_ans  = ans_mem[w_rd_idx];
  assign w_e_mask = mask_mem[w_rd_idx];

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_idx_d  = fail_idx_q;
    fail_code_d = fail_code_q;
    fail_cnt_d  = fail_cnt_q;
    cycle_d     = cycle_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    w_fail      = 1'b0;
    w_code      = 2'd0;
    w_tmo       = 1'b0;
    w_end       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d     = S_RUN;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_idx_d  = '0;
          fail_code_d = 2'd0;
          fail_cnt_d  = '0;
          cycle_d     = '0;
          ptr_d       = '0;
          count_d     = (CFG_COUNT > NUM_CKPT_W) ? NUM_CKPT_W : CFG_COUNT;
        end
      end

      S_RUN: begin
        if (cycle_q != '1) cycle_d = cycle_q + 1'b1;

        // One entry per cycle; a count beyond the entry means it was skipped.
        if (ptr_q < count_q) begin
          if (NUM_INST == w_e_ni) begin
            ptr_d = ptr_q + 1'b1;
            if ((OUTPUT_PORT & w_e_mask) != (w_e_ans & w_e_mask)) begin
              w_fail = 1'b1;
              w_code = 2'd1;
            end
          end else if (NUM_INST > w_e_ni) begin
            ptr_d  = ptr_q + 1'b1;
            w_fail = 1'b1;
            w_code = 2'd2;
          end
        end

        if (w_fail) begin
          if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
          // The counter saturates rather than wrapping, so zero means "no failure yet".
          if (fail_cnt_q == '0) begin
            fail_idx_d  = w_rd_idx;
            fail_code_d = w_code;
          end
        end

        w_tmo = TO_EN && (cycle_q == TO_LAST);
        w_end = HALT || w_tmo || (w_fail && STOP_EN);

        if (w_end) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = !w_tmo && (fail_cnt_d == '0) && (ptr_d == count_q);
          // Report incomplete runs only when nothing failed earlier.
          if ((HALT || w_tmo) && (fail_cnt_d == '0) && (w_tmo || (ptr_d < count_q))) begin
            fail_code_d = 2'd3;
            fail_idx_d  = ptr_d[IDXW-1:0];
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_idx_q  <= '0;
      fail_code_q <= 2'd0;
      fail_cnt_q  <= '0;
      cycle_q     <= '0;
      ptr_q       <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_idx_q  <= fail_idx_d;
      fail_code_q <= fail_code_d;
      fail_cnt_q  <= fail_cnt_d;
      cycle_q     <= cycle_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign FAIL_IDX  = fail_idx_q;
  assign FAIL_CODE = fail_code_q;
  assign FAIL_CNT  = fail_cnt_q;
  assign CYCLE     = cycle_q;
  assign CUR_IDX   = ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_ckpt_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_ckpt_checker
// Purpose  : Self-checking bench for riscv_ckpt_checker. Two instances share
//            the same stimulus. Instance a stops on the first failure and times
//            out after 20 cycles. Instance b continues past failures and has no
//            timeout. Expected end-of-run status is queued per instance when a
//            run is started and popped once DONE is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_ckpt_checker;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        CFG_WE = 1'b0;
  logic [5:0]  CFG_ADDR = '0;
  logic [31:0] CFG_NUM_INST = '0;
  logic [31:0] CFG_ANS = '0;
  logic [31:0] CFG_MASK = '0;
  logic [6:0]  CFG_COUNT = '0;
  logic        START = 1'b0;
  logic [31:0] NUM_INST = '0;
  logic [31:0] OUTPUT_PORT = '0;
  logic        HALT = 1'b0;

  logic a_busy, a_done, a_pass, b_busy, b_done, b_pass;
  logic [5:0]  a_idx, b_idx;
  logic [1:0]  a_code, b_code;
  logic [6:0]  a_cnt, b_cnt, a_cur, b_cur;
  logic [31:0] a_cyc, b_cyc;

  always #5 CLK = ~CLK;

  riscv_ckpt_checker #(.NUM_CKPT(64), .IDXW(6), .IW(32), .DW(32), .CW(32),
                       .TIMEOUT(20), .STOP_ON_FAIL(1)) u_a (
    .CLK(CLK), .RSTn(RSTn), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
    .CFG_NUM_INST(CFG_NUM_INST), .CFG_ANS(CFG_ANS), .CFG_MASK(CFG_MASK),
    .CFG_COUNT(CFG_COUNT), .START(START), .NUM_INST(NUM_INST),
    .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT), .BUSY(a_busy), .DONE(a_done),
    .PASS(a_pass), .FAIL_IDX(a_idx), .FAIL_CODE(a_code), .FAIL_CNT(a_cnt),
    .CYCLE(a_cyc), .CUR_IDX(a_cur));

  riscv_ckpt_checker #(.NUM_CKPT(64), .IDXW(6), .IW(32), .DW(32), .CW(32),
                       .TIMEOUT(0), .STOP_ON_FAIL(0)) u_b (
    .CLK(CLK), .RSTn(RSTn), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
    .CFG_NUM_INST(CFG_NUM_INST), .CFG_ANS(CFG_ANS), .CFG_MASK(CFG_MASK),
    .CFG_COUNT(CFG_COUNT), .START(START), .NUM_INST(NUM_INST),
    .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT), .BUSY(b_busy), .DONE(b_done),
    .PASS(b_pass), .FAIL_IDX(b_idx), .FAIL_CODE(b_code), .FAIL_CNT(b_cnt),
    .CYCLE(b_cyc), .CUR_IDX(b_cur));

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        pass;
    logic [5:0]  idx;
    logic [1:0]  code;
    logic [6:0]  cnt;
    logic [6:0]  cur;
    logic [31:0] cyc;
  } st_t;

  st_t q_a[$];
  st_t q_b[$];
  st_t got, exp, hold;
  int  n_tests = 0;
  int  n_fail  = 0;

  function automatic st_t mk(input logic d, input logic p, input int idx,
                             input int code, input int cnt, input int cur, input int cyc);
    st_t s;
    s.busy = 1'b0; s.done = d; s.pass = p; s.idx = 6'(idx); s.code = 2'(code);
    s.cnt = 7'(cnt); s.cur = 7'(cur); s.cyc = 32'(cyc);
    return s;
  endfunction

  function automatic st_t obs_a();
    return {a_busy, a_done, a_pass, a_idx, a_code, a_cnt, a_cur, a_cyc};
  endfunction

  function automatic st_t obs_b();
    return {b_busy, b_done, b_pass, b_idx, b_code, b_cnt, b_cur, b_cyc};
  endfunction

  function automatic logic [31:0] op_for(input int n);
    case (n)
      4:       return 32'h0000_0f00;
      6:       return 32'h0000_0018;
      8:       return 32'h0000_001d;
      default: return 32'h0;
    endcase
  endfunction

  task automatic step(input int ni, input logic [31:0] op, input logic h);
    NUM_INST = 32'(ni); OUTPUT_PORT = op; HALT = h;
    @(posedge CLK); #1;
  endtask

  task automatic load(input int addr, input int ni, input logic [31:0] ans, input logic [31:0] mask);
    CFG_WE = 1'b1; CFG_ADDR = 6'(addr); CFG_NUM_INST = 32'(ni); CFG_ANS = ans; CFG_MASK = mask;
    @(posedge CLK); #1;
    CFG_WE = 1'b0;
  endtask

  task automatic start_run(input int cnt);
    CFG_COUNT = 7'(cnt); START = 1'b1; HALT = 1'b0; NUM_INST = '0; OUTPUT_PORT = '0;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    n_tests++;
    if (obs_a() !== st_t'(0)) begin n_fail++; $display("FAIL reset_a got %h exp 0", obs_a()); end
    n_tests++;
    if (obs_b() !== st_t'(0)) begin n_fail++; $display("FAIL reset_b got %h exp 0", obs_b()); end
    RSTn = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_pass();
    load(0, 4, 32'h0f00, 32'hffff_ffff);
    load(1, 6, 32'h0018, 32'hffff_ffff);
    load(2, 8, 32'h001d, 32'hffff_ffff);
    q_a.push_back(mk(1, 1, 0, 0, 0, 3, 10));
    q_b.push_back(mk(1, 1, 0, 0, 0, 3, 10));
    start_run(3);
    n_tests++;
    if (a_busy !== 1'b1 || a_cur !== 7'd0) begin
      n_fail++; $display("FAIL pass_busy got busy=%b cur=%0d exp busy=1 cur=0", a_busy, a_cur);
    end
    for (int n = 0; n < 10; n++) step(n, op_for(n), n == 9);
    for (int k = 0; k < 4 && a_done !== 1'b1; k++) begin @(posedge CLK); #1; end
    got = obs_a(); exp = q_a.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL pass_a got %h exp %h", got, exp); end
    got = obs_b(); exp = q_b.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL pass_b got %h exp %h", got, exp); end
  endtask

  task automatic test_stop_on_fail();
    q_a.push_back(mk(1, 0, 1, 1, 1, 2, 7));
    q_b.push_back(mk(1, 0, 1, 1, 1, 3, 10));
    start_run(3);
    for (int n = 0; n < 10; n++) begin
      step(n, (n == 6) ? 32'h0019 : op_for(n), n == 9);
      if (n == 5) begin
        n_tests++;
        if (a_done !== 1'b0) begin n_fail++; $display("FAIL stop_early got done=%b exp 0", a_done); end
      end
      if (n == 6) begin
        got = obs_a(); exp = q_a.pop_front(); hold = exp; n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL stop_a got %h exp %h", got, exp); end
      end
    end
    got = obs_a(); n_tests++;
    if (got !== hold) begin n_fail++; $display("FAIL stop_hold got %h exp %h", got, hold); end
    for (int k = 0; k < 4 && b_done !== 1'b1; k++) begin @(posedge CLK); #1; end
    got = obs_b(); exp = q_b.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL stop_b got %h exp %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    st_t clr;
    clr = '0; clr.busy = 1'b1;
    start_run(3);
    n_tests++;
    if (obs_a() !== clr) begin n_fail++; $display("FAIL b2b_clear_a got %h exp %h", obs_a(), clr); end
    n_tests++;
    if (obs_b() !== clr) begin n_fail++; $display("FAIL b2b_clear_b got %h exp %h", obs_b(), clr); end
    q_a.push_back(mk(1, 0, 0, 1, 1, 1, 5));
    q_b.push_back(mk(1, 0, 0, 1, 2, 3, 10));
    for (int n = 0; n < 10; n++) step(n, (n == 4 || n == 8) ? 32'h0bad : op_for(n), n == 9);
    for (int k = 0; k < 4 && b_done !== 1'b1; k++) begin @(posedge CLK); #1; end
    got = obs_a(); exp = q_a.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL b2b_a got %h exp %h", got, exp); end
    got = obs_b(); exp = q_b.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL b2b_continue_b got %h exp %h", got, exp); end
  endtask

  task automatic test_skip();
    q_a.push_back(mk(1, 0, 1, 2, 1, 2, 7));
    q_b.push_back(mk(1, 0, 1, 2, 1, 3, 9));
    start_run(3);
    for (int n = 0; n < 10; n++) if (n != 6) step(n, op_for(n), n == 9);
    for (int k = 0; k < 4 && b_done !== 1'b1; k++) begin @(posedge CLK); #1; end
    got = obs_a(); exp = q_a.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL skip_a got %h exp %h", got, exp); end
    got = obs_b(); exp = q_b.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL skip_b got %h exp %h", got, exp); end
  endtask

  task automatic test_mask();
    load(1, 6, 32'h1218, 32'h00ff);
    q_a.push_back(mk(1, 1, 0, 0, 0, 3, 10));
    q_b.push_back(mk(1, 1, 0, 0, 0, 3, 10));
    start_run(3);
    for (int n = 0; n < 10; n++) begin
      if (n == 2) begin
        CFG_WE = 1'b1; CFG_ADDR = 6'd2; CFG_NUM_INST = 32'd8;
        CFG_ANS = 32'hdead; CFG_MASK = 32'hffff_ffff;
      end
      if (n == 5) begin START = 1'b1; CFG_COUNT = 7'd0; end
      step(n, op_for(n), n == 9);
      CFG_WE = 1'b0; START = 1'b0;
      if (n == 5) begin
        n_tests++;
        if (a_busy !== 1'b1 || a_cur !== 7'd1 || a_cyc !== 32'd6) begin
          n_fail++;
          $display("FAIL start_in_run got busy=%b cur=%0d cyc=%0d exp busy=1 cur=1 cyc=6", a_busy, a_cur, a_cyc);
        end
      end
    end
    for (int k = 0; k < 4 && a_done !== 1'b1; k++) begin @(posedge CLK); #1; end
    got = obs_a(); exp = q_a.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL mask_cfgwe_a got %h exp %h", got, exp); end
    got = obs_b(); exp = q_b.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL mask_cfgwe_b got %h exp %h", got, exp); end
  endtask

  task automatic test_halt_early();
    q_a.push_back(mk(1, 0, 1, 3, 0, 1, 6));
    q_b.push_back(mk(1, 0, 1, 3, 0, 1, 6));
    start_run(3);
    for (int n = 0; n < 6; n++) step(n, op_for(n), n == 5);
    for (int k = 0; k < 4 && a_done !== 1'b1; k++) begin @(posedge CLK); #1; end
    got = obs_a(); exp = q_a.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL halt_early_a got %h exp %h", got, exp); end
    got = obs_b(); exp = q_b.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL halt_early_b got %h exp %h", got, exp); end
  endtask

  task automatic test_count0();
    q_a.push_back(mk(1, 1, 0, 0, 0, 0, 1));
    q_b.push_back(mk(1, 1, 0, 0, 0, 0, 1));
    start_run(0);
    step(0, 32'h0, 1'b1);
    for (int k = 0; k < 4 && a_done !== 1'b1; k++) begin @(posedge CLK); #1; end
    got = obs_a(); exp = q_a.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL count0_a got %h exp %h", got, exp); end
    got = obs_b(); exp = q_b.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL count0_b got %h exp %h", got, exp); end
  endtask

  task automatic test_timeout();
    q_a.push_back(mk(1, 0, 0, 3, 0, 0, 20));
    start_run(3);
    for (int k = 0; k < 19; k++) step(0, 32'h0, 1'b0);
    n_tests++;
    if (a_done !== 1'b0 || a_cyc !== 32'd19) begin
      n_fail++; $display("FAIL timeout_early got done=%b cyc=%0d exp done=0 cyc=19", a_done, a_cyc);
    end
    step(0, 32'h0, 1'b0);
    got = obs_a(); exp = q_a.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL timeout_a got %h exp %h", got, exp); end
    step(0, 32'h0, 1'b0);
    n_tests++;
    if (a_done !== 1'b1 || a_cyc !== 32'd20) begin
      n_fail++; $display("FAIL timeout_hold got done=%b cyc=%0d exp done=1 cyc=20", a_done, a_cyc);
    end
    n_tests++;
    if (b_busy !== 1'b1 || b_done !== 1'b0) begin
      n_fail++; $display("FAIL timeout_disabled_b got busy=%b done=%b exp busy=1 done=0", b_busy, b_done);
    end
  endtask

  task automatic test_reset_midrun();
    start_run(3);
    n_tests++;
    if (b_busy !== 1'b1 || b_cyc !== 32'd22) begin
      n_fail++; $display("FAIL start_ignored_b got busy=%b cyc=%0d exp busy=1 cyc=22", b_busy, b_cyc);
    end
    step(0, 32'h0, 1'b0);
    step(0, 32'h0, 1'b0);
    #2 RSTn = 1'b0;
    #1;
    n_tests++;
    if (obs_a() !== st_t'(0)) begin n_fail++; $display("FAIL async_reset_a got %h exp 0", obs_a()); end
    n_tests++;
    if (obs_b() !== st_t'(0)) begin n_fail++; $display("FAIL async_reset_b got %h exp 0", obs_b()); end
    #2 RSTn = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_table_kept();
    q_a.push_back(mk(1, 1, 0, 0, 0, 3, 10));
    start_run(3);
    for (int n = 0; n < 10; n++) step(n, op_for(n), n == 9);
    for (int k = 0; k < 4 && a_done !== 1'b1; k++) begin @(posedge CLK); #1; end
    got = obs_a(); exp = q_a.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL table_kept_a got %h exp %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_stop_on_fail();
    test_back_to_back();
    test_skip();
    test_mask();
    test_halt_early();
    test_count0();
    test_timeout();
    test_reset_midrun();
    test_table_kept();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
